// File: rtl/cdb_arbiter_pkg.sv
// Shared types and helpers for the CDB arbiter: bus widths, FU source ids,
// the broadcast payload struct and ROB-age comparison.
package cdb_arbiter_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = 5;
  localparam int TAG_W     = ROB_TAG_W;
  localparam int PREG_W    = 7;
  localparam int DATA_W    = 32;
  localparam int NUM_FU    = 3;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_B   = 2'd1,
    FU_MEM = 2'd2
  } fu_src_e;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [PREG_W-1:0] pd;
    logic [DATA_W-1:0] data;
    fu_src_e           src;
  } cdb_t;

  localparam int CDB_W = $bits(cdb_t);

  // Distance from the ROB head; only the low 4 bits index the 16-entry ROB.
  function automatic logic [3:0] rob_age(input logic [TAG_W-1:0] t,
                                         input logic [TAG_W-1:0] head);
    return 4'(t - head);
  endfunction

  function automatic logic is_younger(input logic [TAG_W-1:0] t,
                                      input logic [TAG_W-1:0] branch,
                                      input logic [TAG_W-1:0] head);
    return rob_age(t, head) > rob_age(branch, head);
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle of FU result ports, flush controls and the CDB broadcast.
// Handshake: a result transfers on a rising edge where x_valid && x_ready;
// the FU holds tag/pd/data stable while x_valid is high and x_ready is low.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic              alu_valid, b_valid, mem_valid;
  logic              alu_ready, b_ready, mem_ready;
  logic [TAG_W-1:0]  alu_tag, b_tag, mem_tag;
  logic [PREG_W-1:0] alu_pd, b_pd, mem_pd;
  logic [DATA_W-1:0] alu_data, b_data, mem_data;

  logic [TAG_W-1:0]  rob_head;
  logic              mispredict;
  logic [TAG_W-1:0]  mispredict_tag;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [PREG_W-1:0] cdb_pd;
  logic [DATA_W-1:0] cdb_data;
  logic [1:0]        cdb_src;

  // Observability of internal state: round-robin pointer and slot occupancy.
  logic [1:0]        rr_ptr;
  logic [2:0]        slot_valid;

  modport master (
    output alu_valid, b_valid, mem_valid,
    output alu_tag, b_tag, mem_tag, alu_pd, b_pd, mem_pd,
    output alu_data, b_data, mem_data,
    output rob_head, mispredict, mispredict_tag,
    input  alu_ready, b_ready, mem_ready,
    input  cdb_valid, cdb_tag, cdb_pd, cdb_data, cdb_src,
    input  rr_ptr, slot_valid
  );

  modport slave (
    input  alu_valid, b_valid, mem_valid,
    input  alu_tag, b_tag, mem_tag, alu_pd, b_pd, mem_pd,
    input  alu_data, b_data, mem_data,
    input  rob_head, mispredict, mispredict_tag,
    output alu_ready, b_ready, mem_ready,
    output cdb_valid, cdb_tag, cdb_pd, cdb_data, cdb_src,
    output rr_ptr, slot_valid
  );

endinterface

// File: rtl/cdb_arbiter_slot.sv
// One-entry holding register for a single FU result, freed by a grant or a
// squash and refillable on the same edge it is granted.
module cdb_arbiter_slot
  import cdb_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic capture,
  input  logic drop,
  input  logic squash,
  input  logic grant,
  input  cdb_t d,
  output logic valid,
  output cdb_t q,
  output logic ready
);

  assign ready = !valid || grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (capture) begin
      // A result younger than a mispredicted branch is taken and discarded.
      valid <= !drop;
      q     <= d;
    end else if (grant || squash) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter of ALU/branch/memory completions onto a registered
// common data bus, with mispredict squashing by ROB age.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  cdb_arbiter_if.slave bus
);

  logic [NUM_FU-1:0] in_valid;
  logic [NUM_FU-1:0] ready;
  logic [NUM_FU-1:0] slot_valid;
  logic [NUM_FU-1:0] squash;
  logic [NUM_FU-1:0] drop;
  logic [NUM_FU-1:0] eligible;
  logic [NUM_FU-1:0] grant;
  cdb_t              in_d   [NUM_FU];
  cdb_t              slot_q [NUM_FU];

  logic [1:0] rr_ptr;
  logic [1:0] grant_idx;
  logic       any_grant;
  logic [2:0] cand;

  logic       cdb_valid;
  cdb_t       cdb_q;

  assign in_valid = {bus.mem_valid, bus.b_valid, bus.alu_valid};
  assign in_d[0]  = '{tag: bus.alu_tag, pd: bus.alu_pd, data: bus.alu_data, src: FU_ALU};
  assign in_d[1]  = '{tag: bus.b_tag,   pd: bus.b_pd,   data: bus.b_data,   src: FU_B};
  assign in_d[2]  = '{tag: bus.mem_tag, pd: bus.mem_pd, data: bus.mem_data, src: FU_MEM};

  for (genvar i = 0; i < NUM_FU; i++) begin : g_slot
    assign squash[i] = bus.mispredict && slot_valid[i] &&
                       is_younger(slot_q[i].tag, bus.mispredict_tag, bus.rob_head);
    assign drop[i]   = bus.mispredict &&
                       is_younger(in_d[i].tag, bus.mispredict_tag, bus.rob_head);

    cdb_arbiter_slot u_slot (
      .clk     (clk),
      .reset   (reset),
      .capture (in_valid[i] && ready[i]),
      .drop    (drop[i]),
      .squash  (squash[i]),
      .grant   (grant[i]),
      .d       (in_d[i]),
      .valid   (slot_valid[i]),
      .q       (slot_q[i]),
      .ready   (ready[i])
    );
  end

  assign eligible = slot_valid & ~squash;

  // Search rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); first eligible slot wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      cand = {1'b0, rr_ptr} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!any_grant && eligible[cand[1:0]]) begin
        any_grant = 1'b1;
        grant_idx = cand[1:0];
      end
    end
    grant[grant_idx] = any_grant;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= 2'd0;
    end else if (any_grant) begin
      rr_ptr <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
    end
  end

  // Payload keeps its last value when nothing is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdb_valid <= 1'b0;
      cdb_q     <= '0;
    end else begin
      cdb_valid <= any_grant;
      if (any_grant) cdb_q <= slot_q[grant_idx];
    end
  end

  assign bus.alu_ready  = ready[0];
  assign bus.b_ready    = ready[1];
  assign bus.mem_ready  = ready[2];
  assign bus.cdb_valid  = cdb_valid;
  assign bus.cdb_tag    = cdb_q.tag;
  assign bus.cdb_pd     = cdb_q.pd;
  assign bus.cdb_data   = cdb_q.data;
  assign bus.cdb_src    = cdb_q.src;
  assign bus.rr_ptr     = rr_ptr;
  assign bus.slot_valid = slot_valid;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts are queued as results
// are offered and compared against every cdb_valid pulse.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  logic [CDB_W-1:0] exp_q[$];

  cdb_arbiter_if bus();

  cdb_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.alu_valid = 1'b0;
    bus.b_valid   = 1'b0;
    bus.mem_valid = 1'b0;
  endtask

  task automatic drive(input int fu, input logic [4:0] tag, input logic [6:0] pd,
                       input logic [31:0] data);
    case (fu)
      0: begin bus.alu_valid = 1'b1; bus.alu_tag = tag; bus.alu_pd = pd; bus.alu_data = data; end
      1: begin bus.b_valid   = 1'b1; bus.b_tag   = tag; bus.b_pd   = pd; bus.b_data   = data; end
      default: begin bus.mem_valid = 1'b1; bus.mem_tag = tag; bus.mem_pd = pd; bus.mem_data = data; end
    endcase
  endtask

  task automatic push_exp(input logic [4:0] tag, input logic [6:0] pd,
                          input logic [31:0] data, input logic [1:0] src);
    exp_q.push_back({tag, pd, data, src});
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // Scoreboard
  always @(negedge clk) begin
    if (!reset && bus.cdb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("cdb_unexpected_valid", 64'(bus.cdb_valid), 64'd0);
      end else begin
        logic [CDB_W-1:0] exp_v;
        exp_v = exp_q.pop_front();
        check("cdb_payload", 64'({bus.cdb_tag, bus.cdb_pd, bus.cdb_data, bus.cdb_src}),
              64'(exp_v));
      end
    end
  end

  initial begin
    int ai, bi;
    logic a_acc, b_acc;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    idle_all();
    bus.alu_tag = '0; bus.b_tag = '0; bus.mem_tag = '0;
    bus.alu_pd = '0; bus.b_pd = '0; bus.mem_pd = '0;
    bus.alu_data = '0; bus.b_data = '0; bus.mem_data = '0;
    bus.rob_head = '0;
    bus.mispredict = 1'b0;
    bus.mispredict_tag = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    check("rst_cdb_payload", 64'({bus.cdb_tag, bus.cdb_pd, bus.cdb_data, bus.cdb_src}), 64'd0);
    check("rst_slot_valid", 64'(bus.slot_valid), 64'd0);
    check("rst_rr_ptr", 64'(bus.rr_ptr), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_readys", 64'({bus.mem_ready, bus.b_ready, bus.alu_ready}), 64'b111);

    // Single ALU result: broadcast one edge after capture
    tick();
    drive(0, 5'd2, 7'h20, 32'hDEAD);
    push_exp(5'd2, 7'h20, 32'hDEAD, 2'd0);
    tick();
    idle_all();
    @(negedge clk);
    check("t1_no_early_bcast", 64'(bus.cdb_valid), 64'd0);
    drain("t1_drain");
    check("t1_rr_ptr", 64'(bus.rr_ptr), 64'd1);

    // One MEM result to bring rr_ptr back to 0
    tick();
    drive(2, 5'd9, 7'h09, 32'h9999);
    push_exp(5'd9, 7'h09, 32'h9999, 2'd2);
    tick();
    idle_all();
    drain("mem_drain");
    check("rr_after_mem", 64'(bus.rr_ptr), 64'd0);

    // All three FUs in the same cycle
    tick();
    drive(0, 5'd1, 7'h11, 32'h1111_0001);
    drive(1, 5'd2, 7'h12, 32'h2222_0002);
    drive(2, 5'd3, 7'h13, 32'h3333_0003);
    push_exp(5'd1, 7'h11, 32'h1111_0001, 2'd0);
    push_exp(5'd2, 7'h12, 32'h2222_0002, 2'd1);
    push_exp(5'd3, 7'h13, 32'h3333_0003, 2'd2);
    tick();
    idle_all();
    drain("t2_drain");
    check("t2_rr_ptr", 64'(bus.rr_ptr), 64'd0);

    // ALU back-to-back stream
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(0, 5'(10 + i), 7'(i + 64), $urandom);
      push_exp(5'(10 + i), 7'(i + 64), bus.alu_data, 2'd0);
      @(negedge clk);
      check("t3_alu_ready", 64'(bus.alu_ready), 64'd1);
      if (i >= 2) check("t3_bcast_each_cycle", 64'(bus.cdb_valid), 64'd1);
      tick();
    end
    idle_all();
    drain("t3_drain");
    check("t3_rr_ptr", 64'(bus.rr_ptr), 64'd1);

    // ALU and branch streaming together: grants alternate B, ALU, ...
    push_exp(5'd2, 7'h22, 32'hB000_0000, 2'd1);
    push_exp(5'd1, 7'h21, 32'hA000_0000, 2'd0);
    push_exp(5'd4, 7'h24, 32'hB000_0001, 2'd1);
    push_exp(5'd3, 7'h23, 32'hA000_0001, 2'd0);
    push_exp(5'd6, 7'h26, 32'hB000_0002, 2'd1);
    push_exp(5'd5, 7'h25, 32'hA000_0002, 2'd0);
    ai = 0;
    bi = 0;
    tick();
    for (int k = 0; k < 20 && (ai < 3 || bi < 3); k++) begin
      if (ai < 3) drive(0, 5'(2 * ai + 1), 7'(8'h21 + 2 * ai), 32'hA000_0000 + 32'(ai));
      else bus.alu_valid = 1'b0;
      if (bi < 3) drive(1, 5'(2 * bi + 2), 7'(8'h22 + 2 * bi), 32'hB000_0000 + 32'(bi));
      else bus.b_valid = 1'b0;
      @(negedge clk);
      a_acc = bus.alu_valid && bus.alu_ready;
      b_acc = bus.b_valid && bus.b_ready;
      if (ai < 3 && k > 0) check("t3b_alu_ready", 64'(bus.alu_ready), 64'(k % 2 == 0));
      if (bi < 3 && k > 0) check("t3b_b_ready", 64'(bus.b_ready), 64'(k % 2 == 1));
      tick();
      if (a_acc) ai++;
      if (b_acc) bi++;
    end
    idle_all();
    drain("t3b_drain");
    check("t3b_rr_ptr", 64'(bus.rr_ptr), 64'd1);

    // Mispredict: head=3, branch=5; tags 6 and 7 squashed, 4 proceeds
    tick();
    bus.rob_head = 5'd3;
    drive(0, 5'd4, 7'h04, 32'h0000_0444);
    drive(1, 5'd6, 7'h06, 32'h0000_0666);
    drive(2, 5'd7, 7'h07, 32'h0000_0777);
    push_exp(5'd4, 7'h04, 32'h0000_0444, 2'd0);
    tick();
    idle_all();
    bus.mispredict = 1'b1;
    bus.mispredict_tag = 5'd5;
    @(negedge clk);
    check("t4_slots_full", 64'(bus.slot_valid), 64'b111);
    check("t4_b_ready_held", 64'(bus.b_ready), 64'd0);
    tick();
    bus.mispredict = 1'b0;
    @(negedge clk);
    check("t4_slots_cleared", 64'(bus.slot_valid), 64'd0);
    drain("t4_drain");

    // Wrap-around: head=14, branch=15; tag 0 squashed, young incoming tag 1 dropped
    tick();
    bus.rob_head = 5'd14;
    drive(0, 5'd14, 7'h0E, 32'h0000_EEEE);
    drive(1, 5'd0, 7'h10, 32'h0000_0000);
    push_exp(5'd14, 7'h0E, 32'h0000_EEEE, 2'd0);
    tick();
    idle_all();
    bus.mispredict = 1'b1;
    bus.mispredict_tag = 5'd15;
    drive(2, 5'd1, 7'h31, 32'h0000_1111);
    @(negedge clk);
    check("t5_mem_ready", 64'(bus.mem_ready), 64'd1);
    tick();
    bus.mispredict = 1'b0;
    idle_all();
    @(negedge clk);
    check("t5_slots_cleared", 64'(bus.slot_valid), 64'd0);
    drain("t5_drain");
    check("t5_rr_ptr", 64'(bus.rr_ptr), 64'd1);

    // Mispredict tag equal to a buffered tag: the branch itself still broadcasts
    tick();
    bus.rob_head = 5'd0;
    drive(0, 5'd3, 7'h03, 32'h0000_0333);
    drive(1, 5'd5, 7'h05, 32'h0000_0555);
    push_exp(5'd5, 7'h05, 32'h0000_0555, 2'd1);
    push_exp(5'd3, 7'h03, 32'h0000_0333, 2'd0);
    tick();
    idle_all();
    bus.mispredict = 1'b1;
    bus.mispredict_tag = 5'd5;
    tick();
    bus.mispredict = 1'b0;
    drain("t6_drain");

    // Reset asserted mid-stream with two slots full
    tick();
    drive(0, 5'd7, 7'h07, 32'h7777_7777);
    drive(2, 5'd8, 7'h08, 32'h8888_8888);
    tick();
    idle_all();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t7_async_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    check("t7_async_slots", 64'(bus.slot_valid), 64'd0);
    check("t7_async_cdb_tag", 64'(bus.cdb_tag), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("t7_rr_ptr", 64'(bus.rr_ptr), 64'd0);
    check("t7_queue_empty", 64'(exp_q.size()), 64'd0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
